// File: rtl/button_event_arbiter.sv
// Debounces N raw push buttons, queues one press per channel and serialises the
// presses onto a single valid/ready event port with a round-robin arbiter.
module button_event_arbiter #(
  parameter  int N         = 4,
  parameter  int DB_CYCLES = 4,
  localparam int IDW       = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   btn_in,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic           clr_overrun
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(N - 1);

  logic [N-1:0]   sync1_r;
  logic [N-1:0]   sync2_r;
  logic [N-1:0]   db_r;
  logic [CW-1:0]  cnt_r [N];
  logic [IDW-1:0] ptr_r;

  logic [N-1:0]   rise_s;
  logic [N-1:0]   grant_s;
  logic           load_s;
  logic           found_s;
  logic [IDW-1:0] gnt_id_s;

  // Press = debounced level flipping 0->1 on this edge.
  always_comb begin
    rise_s = '0;
    for (int i = 0; i < N; i++) begin
      rise_s[i] = sync2_r[i] & ~db_r[i] & (cnt_r[i] == CNT_LAST);
    end
  end

  // Round-robin pick of the first pending channel after the last winner.
  always_comb begin
    logic [IDW-1:0] cand;
    cand     = '0;
    found_s  = 1'b0;
    gnt_id_s = '0;
    grant_s  = '0;
    load_s   = ~evt_valid | evt_ready;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_r) + k) % N);
      if (!found_s && pending[cand]) begin
        found_s  = 1'b1;
        gnt_id_s = cand;
      end else begin
        found_s  = found_s;
      end
    end
    if (load_s && found_s) begin
      grant_s[gnt_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Two-flop synchroniser and per-channel debounce counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      db_r    <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      for (int i = 0; i < N; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // One-deep pending slot per channel; a fresh press beats its own grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rise_s[i]) begin
          pending[i] <= 1'b1;
        end else if (grant_s[i]) begin
          pending[i] <= 1'b0;
        end else begin
          pending[i] <= pending[i];
        end
        if (rise_s[i] && pending[i] && !grant_s[i]) begin
          overrun[i] <= 1'b1;
        end else if (clr_overrun) begin
          overrun[i] <= 1'b0;
        end else begin
          overrun[i] <= overrun[i];
        end
      end
    end
  end

  // Output slot reloads only when empty or being accepted, so a stalled event stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr_r     <= PTR_INIT;
    end else if (load_s) begin
      if (found_s) begin
        evt_valid <= 1'b1;
        evt_id    <= gnt_id_s;
        ptr_r     <= gnt_id_s;
      end else begin
        evt_valid <= 1'b0;
      end
    end else begin
      evt_valid <= evt_valid;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: a window-based reference model
// predicts events and state, a negedge monitor pops and compares.
module tb_button_event_arbiter;
  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         clr_overrun;

  always #5 clk = ~clk;

  button_event_arbiter #(.N(N), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // reference model state (expected DUT state after the latest edge)
  logic [N-1:0] m_s1, m_s2, m_db, m_pend, m_ovr;
  bit           m_valid;
  int           m_id, m_ptr;
  logic [N-1:0] s2_hist[$];
  int           exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [N-1:0] rise, grant, nxt_db;
    bit found, load, all_diff;
    int gid, c;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_ovr = '0;
      m_valid = 1'b0; m_id = 0; m_ptr = N - 1;
      s2_hist.delete();
      exp_q.delete();
      return;
    end
    // debounced level flips once the last DB synced samples all disagree with it
    s2_hist.push_back(m_s2);
    if (s2_hist.size() > DB) void'(s2_hist.pop_front());
    rise = '0;
    nxt_db = m_db;
    for (int ch = 0; ch < N; ch++) begin
      all_diff = (s2_hist.size() == DB);
      for (int j = 0; j < s2_hist.size(); j++)
        if (s2_hist[j][ch] == m_db[ch]) all_diff = 1'b0;
      if (all_diff) begin
        nxt_db[ch] = ~m_db[ch];
        rise[ch]   = nxt_db[ch];
      end
    end
    load = !m_valid || evt_ready;
    found = 1'b0;
    gid = 0;
    grant = '0;
    if (load) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && m_pend[c]) begin
          found = 1'b1;
          gid = c;
        end
      end
    end
    if (found) grant[gid] = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      if (rise[ch] && m_pend[ch] && !grant[ch]) m_ovr[ch] = 1'b1;
      else if (clr_overrun) m_ovr[ch] = 1'b0;
    end
    m_pend = (m_pend & ~grant) | rise;
    if (load) begin
      if (found) begin
        m_valid = 1'b1;
        m_id = gid;
        m_ptr = gid;
        exp_q.push_back(gid);
      end else begin
        m_valid = 1'b0;
      end
    end
    m_db = nxt_db;
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      model_step();
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Monitor: state against the model every cycle, event ids from the scoreboard on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("evt_valid", evt_valid, m_valid);
      chk("pending", pending, m_pend);
      chk("overrun", overrun, m_ovr);
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL evt_unexpected: got id %0d expected no event at %0t", evt_id, $time);
        end else begin
          chk("evt_id", evt_id, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn_in = '0; evt_ready = 1'b0; clr_overrun = 1'b0;

    // T1: reset with all buttons held, then ids 0..3 after release
    btn_in = 4'b1111;
    cyc(1);
    mon_en = 1'b1;
    cyc(1);
    chk("t1_valid_rst", evt_valid, 1'b0);
    chk("t1_pending_rst", pending, 4'b0000);
    chk("t1_overrun_rst", overrun, 4'b0000);
    rst_n = 1'b1; evt_ready = 1'b1;
    cyc(7);
    chk("t1_first_valid", evt_valid, 1'b1);
    chk("t1_first_id", evt_id, 2'd0);
    cyc(5);
    btn_in = '0;
    cyc(10);

    // T2: clean press, 7-edge latency, one cycle only
    btn_in = 4'b0100;
    cyc(6);
    chk("t2_not_yet", evt_valid, 1'b0);
    cyc(1);
    chk("t2_valid", evt_valid, 1'b1);
    chk("t2_id", evt_id, 2'd2);
    cyc(1);
    chk("t2_one_cycle", evt_valid, 1'b0);
    btn_in = '0;
    cyc(10);

    // T3: bounce shorter than debounce window, then a real press
    btn_in = 4'b0010; cyc(3);
    btn_in = 4'b0000; cyc(1);
    btn_in = 4'b0010; cyc(3);
    btn_in = 4'b0000; cyc(10);
    chk("t3_no_pending", pending, 4'b0000);
    btn_in = 4'b0010; cyc(10);
    btn_in = 4'b0000; cyc(10);

    // T4: two simultaneous presses, stalled consumer
    reset_dut();
    evt_ready = 1'b0; btn_in = 4'b1001;
    cyc(7);
    chk("t4_id0", evt_id, 2'd0);
    chk("t4_pend", pending, 4'b1000);
    evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    chk("t4_id3", evt_id, 2'd3);
    chk("t4_pend0", pending, 4'b0000);
    cyc(2);
    chk("t4_hold_valid", evt_valid, 1'b1);
    chk("t4_hold_id", evt_id, 2'd3);
    evt_ready = 1'b1; cyc(1);
    chk("t4_empty", evt_valid, 1'b0);
    btn_in = '0; cyc(10);

    // T5: round robin over all four channels, back to back
    reset_dut();
    evt_ready = 1'b0; btn_in = 4'b1111;
    cyc(8);
    chk("t5_id0", evt_id, 2'd0);
    evt_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      cyc(1);
      chk("t5_rr_id", evt_id, k);
    end
    btn_in = '0; cyc(10);

    // T6: overrun while channel already pending, then clear
    reset_dut();
    evt_ready = 1'b0; btn_in = 4'b0001;
    cyc(7);
    btn_in = 4'b0011; cyc(8);
    btn_in = 4'b0001; cyc(8);
    btn_in = 4'b0011; cyc(8);
    chk("t6_pend", pending, 4'b0010);
    chk("t6_ovr", overrun, 4'b0010);
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    chk("t6_ovr_clr", overrun, 4'b0000);
    chk("t6_pend_kept", pending, 4'b0010);
    evt_ready = 1'b1; btn_in = '0; cyc(10);

    // Random phases with varying consumer throughput
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 500; i++) begin
        for (int ch = 0; ch < N; ch++)
          if ($urandom_range(0, 7) == 0) btn_in[ch] = ~btn_in[ch];
        evt_ready   = ($urandom_range(0, 11) < (p * 2 + 1));
        clr_overrun = ($urandom_range(0, 31) == 0);
        rst_n       = ($urandom_range(0, 399) != 0);
        cyc(1);
      end
    end

    // Drain
    rst_n = 1'b1; evt_ready = 1'b1; btn_in = '0; clr_overrun = 1'b0;
    cyc(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
